// File: rtl/window_line_sched.sv
// Line-buffer scheduler for a sliding vertical window: rotates the write select
// over WIN_SIZE+1 line buffers and issues one read-start pulse per complete window.
module window_line_sched #(
    parameter int WIN_SIZE   = 3,
    parameter int LINE_CNT_W = 13,
    localparam int NUM_BUFS  = WIN_SIZE + 1,
    localparam int IDX_W     = $clog2(NUM_BUFS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  line_end_i,
    input  logic                  frame_start_i,
    input  logic                  frame_end_i,
    input  logic                  rd_ready_i,
    input  logic                  rd_line_done_i,
    output logic [NUM_BUFS-1:0]   wr_buf_sel_o,
    output logic [NUM_BUFS-1:0]   rd_buf_mask_o,
    output logic [IDX_W-1:0]      rd_oldest_idx_o,
    output logic                  pop_o,
    output logic                  win_first_o,
    output logic                  win_last_o,
    output logic [LINE_CNT_W-1:0] rd_line_cnt_o,
    output logic                  err_overflow_o,
    output logic                  err_trunc_o
);

    localparam int LS_W = $clog2(NUM_BUFS + 1);
    localparam logic [LS_W-1:0]       LS_ZERO  = LS_W'(0);
    localparam logic [LS_W-1:0]       LS_ONE   = LS_W'(1);
    localparam logic [LS_W-1:0]       LS_WIN   = LS_W'(WIN_SIZE);
    localparam logic [LS_W-1:0]       LS_FULL  = LS_W'(NUM_BUFS);
    localparam logic [IDX_W-1:0]      IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_BUFS - 1);
    localparam logic [NUM_BUFS-1:0]   WR_RST   = {{(NUM_BUFS-1){1'b0}}, 1'b1};
    localparam logic [NUM_BUFS-1:0]   RD_RST   = {{(NUM_BUFS-WIN_SIZE){1'b0}}, {WIN_SIZE{1'b1}}};
    localparam logic [LINE_CNT_W-1:0] CNT_ZERO = LINE_CNT_W'(0);
    localparam logic [LINE_CNT_W-1:0] CNT_ONE  = LINE_CNT_W'(1);
    localparam logic [LINE_CNT_W-1:0] CNT_MAX  = {LINE_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LS_W-1:0]       r_lines_stored;
    logic [LS_W-1:0]       w_ls_next;
    logic                  r_rd_busy;
    logic [NUM_BUFS-1:0]   r_wr_sel;
    logic [NUM_BUFS-1:0]   r_rd_mask;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_pop;
    logic                  r_first;
    logic                  r_last;
    logic [LINE_CNT_W-1:0] r_cnt;
    logic                  r_err_ovf;
    logic                  r_err_trunc;

    logic w_active, w_start_idle, w_trunc, w_restart;
    logic w_le, w_done, w_fe, w_full, w_pop_go;

    function automatic logic [NUM_BUFS-1:0] rotl1(input logic [NUM_BUFS-1:0] v);
        return {v[NUM_BUFS-2:0], v[NUM_BUFS-1]};
    endfunction

    assign w_active     = (r_state != S_IDLE);
    assign w_start_idle = !w_active && push_i && frame_start_i;
    assign w_trunc      = w_active && push_i && frame_start_i;
    assign w_restart    = w_start_idle || w_trunc;
    // A truncating frame start discards whatever else arrives in that cycle.
    assign w_le         = w_active && push_i && line_end_i && !w_trunc;
    assign w_fe         = w_active && push_i && frame_end_i && !w_trunc;
    assign w_done       = w_active && rd_line_done_i && !w_trunc;
    assign w_full       = (r_lines_stored == LS_FULL);

    // Next occupancy of the buffer ring.
    always_comb begin
        w_ls_next = r_lines_stored;
        if (w_restart) begin
            w_ls_next = LS_ZERO;
        end else if (w_le && !w_done) begin
            if (!w_full) begin
                w_ls_next = r_lines_stored + LS_ONE;
            end else begin
                w_ls_next = r_lines_stored;
            end
        end else if (w_done && !w_le) begin
            if (r_lines_stored != LS_ZERO) begin
                w_ls_next = r_lines_stored - LS_ONE;
            end else begin
                w_ls_next = r_lines_stored;
            end
        end else begin
            w_ls_next = r_lines_stored;
        end
    end

    // Frame sequencing next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_idle) w_state_next = S_PRIME;
                else              w_state_next = S_IDLE;
            end
            S_PRIME: begin
                if (w_trunc)                 w_state_next = S_PRIME;
                else if (w_fe)               w_state_next = S_FLUSH;
                else if (w_ls_next >= LS_WIN) w_state_next = S_RUN;
                else                         w_state_next = S_PRIME;
            end
            S_RUN: begin
                if (w_trunc)   w_state_next = S_PRIME;
                else if (w_fe) w_state_next = S_FLUSH;
                else           w_state_next = S_RUN;
            end
            S_FLUSH: begin
                if (w_trunc)                 w_state_next = S_PRIME;
                else if (w_ls_next < LS_WIN) w_state_next = S_IDLE;
                else                         w_state_next = S_FLUSH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_pop_go = ((r_state == S_RUN) || (r_state == S_FLUSH)) && rd_ready_i &&
                      (r_lines_stored >= LS_WIN) && !r_rd_busy && !w_trunc &&
                      (w_state_next != S_IDLE);

    // State, occupancy and read-busy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_lines_stored <= LS_ZERO;
            r_rd_busy      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_lines_stored <= w_ls_next;
            if (w_restart)   r_rd_busy <= 1'b0;
            else if (w_pop_go) r_rd_busy <= 1'b1;
            else if (w_done) r_rd_busy <= 1'b0;
            else             r_rd_busy <= r_rd_busy;
        end
    end

    // Write select and read window pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_sel  <= WR_RST;
            r_rd_mask <= RD_RST;
            r_rd_idx  <= IDX_ZERO;
        end else if (w_restart) begin
            r_wr_sel  <= WR_RST;
            r_rd_mask <= RD_RST;
            r_rd_idx  <= IDX_ZERO;
        end else begin
            if (w_le) r_wr_sel <= rotl1(r_wr_sel);
            if (w_done) begin
                r_rd_mask <= rotl1(r_rd_mask);
                r_rd_idx  <= (r_rd_idx == IDX_MAX) ? IDX_ZERO : (r_rd_idx + IDX_ONE);
            end
        end
    end

    // Read-start pulse and its qualifiers, evaluated as they will be seen at pop time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pop   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_pop   <= w_pop_go;
            r_first <= w_pop_go && (r_cnt == CNT_ZERO);
            r_last  <= w_pop_go && (w_state_next == S_FLUSH) && (w_ls_next == LS_WIN);
        end
    end

    // Per-frame window counter and sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= CNT_ZERO;
            r_err_ovf   <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            if (w_restart)                     r_cnt <= CNT_ZERO;
            else if (r_pop && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
            else                               r_cnt <= r_cnt;

            if (w_start_idle)        r_err_ovf <= 1'b0;
            else if (w_le && w_full) r_err_ovf <= 1'b1;
            else                     r_err_ovf <= r_err_ovf;

            if (w_start_idle) r_err_trunc <= 1'b0;
            else if (w_trunc) r_err_trunc <= 1'b1;
            else              r_err_trunc <= r_err_trunc;
        end
    end

    assign wr_buf_sel_o    = r_wr_sel;
    assign rd_buf_mask_o   = r_rd_mask;
    assign rd_oldest_idx_o = r_rd_idx;
    assign pop_o           = r_pop;
    assign win_first_o     = r_first;
    assign win_last_o      = r_last;
    assign rd_line_cnt_o   = r_cnt;
    assign err_overflow_o  = r_err_ovf;
    assign err_trunc_o     = r_err_trunc;

endmodule

// File: tb/tb_window_line_sched.sv
// Directed bench for window_line_sched with WIN_SIZE=3 (four line buffers).
module tb_window_line_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_i = 1'b0;
    logic        line_end_i = 1'b0;
    logic        frame_start_i = 1'b0;
    logic        frame_end_i = 1'b0;
    logic        rd_ready_i = 1'b0;
    logic        rd_line_done_i = 1'b0;
    logic [3:0]  wr_buf_sel_o;
    logic [3:0]  rd_buf_mask_o;
    logic [1:0]  rd_oldest_idx_o;
    logic        pop_o;
    logic        win_first_o;
    logic        win_last_o;
    logic [12:0] rd_line_cnt_o;
    logic        err_overflow_o;
    logic        err_trunc_o;

    int passed = 0;
    int total  = 0;
    int pops   = 0;
    int rd_cd  = 0;
    bit auto_rd = 1'b0;
    logic [7:0] first_bits;
    logic [7:0] last_bits;

    window_line_sched #(.WIN_SIZE(3), .LINE_CNT_W(13)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .push_i         (push_i),
        .line_end_i     (line_end_i),
        .frame_start_i  (frame_start_i),
        .frame_end_i    (frame_end_i),
        .rd_ready_i     (rd_ready_i),
        .rd_line_done_i (rd_line_done_i),
        .wr_buf_sel_o   (wr_buf_sel_o),
        .rd_buf_mask_o  (rd_buf_mask_o),
        .rd_oldest_idx_o(rd_oldest_idx_o),
        .pop_o          (pop_o),
        .win_first_o    (win_first_o),
        .win_last_o     (win_last_o),
        .rd_line_cnt_o  (rd_line_cnt_o),
        .err_overflow_o (err_overflow_o),
        .err_trunc_o    (err_trunc_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock; sample just after the edge, then model the reader's response.
    task automatic tick();
        @(posedge clk_i);
        #1;
        rd_line_done_i = 1'b0;
        if (auto_rd && rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) rd_line_done_i = 1'b1;
        end
        if (pop_o) begin
            if (pops < 8) begin
                first_bits[pops] = win_first_o;
                last_bits[pops]  = win_last_o;
            end
            pops++;
            rd_cd = 10;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic fs, input logic le, input logic fe);
        push_i = 1'b1; frame_start_i = fs; line_end_i = le; frame_end_i = fe;
        tick();
        push_i = 1'b0; frame_start_i = 1'b0; line_end_i = 1'b0; frame_end_i = 1'b0;
    endtask

    task automatic do_reset();
        push_i = 1'b0; line_end_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0;
        rd_ready_i = 1'b0; rd_line_done_i = 1'b0; auto_rd = 1'b0;
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        tick();
        rd_cd = 0; pops = 0; first_bits = 8'h00; last_bits = 8'h00;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
        tick();
        total++; if (wr_buf_sel_o !== 4'b0001) $display("FAIL reset_wr got=%b exp=0001", wr_buf_sel_o); else passed++;
        total++; if (rd_buf_mask_o !== 4'b0111) $display("FAIL reset_mask got=%b exp=0111", rd_buf_mask_o); else passed++;
        total++; if (rd_oldest_idx_o !== 2'd0) $display("FAIL reset_idx got=%0d exp=0", rd_oldest_idx_o); else passed++;
        total++; if ({pop_o, win_first_o, win_last_o, err_overflow_o, err_trunc_o} !== 5'b00000)
            $display("FAIL reset_flags got=%b exp=00000", {pop_o, win_first_o, win_last_o, err_overflow_o, err_trunc_o}); else passed++;
        total++; if (rd_line_cnt_o !== 13'd0) $display("FAIL reset_cnt got=%0d exp=0", rd_line_cnt_o); else passed++;
        total++; if (dut.r_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dut.r_state); else passed++;
    endtask

    task automatic test_frame();
        do_reset();
        rd_ready_i = 1'b1; auto_rd = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            send(1'b0, 1'b1, (k == 5) ? 1'b1 : 1'b0);
            idle(19);
        end
        idle(10);
        total++; if (pops !== 3) $display("FAIL frame_pops got=%0d exp=3", pops); else passed++;
        total++; if (first_bits[2:0] !== 3'b001) $display("FAIL frame_first got=%b exp=001", first_bits[2:0]); else passed++;
        total++; if (last_bits[2:0] !== 3'b100) $display("FAIL frame_last got=%b exp=100", last_bits[2:0]); else passed++;
        total++; if (dut.r_state !== 2'd0) $display("FAIL frame_state got=%0d exp=0", dut.r_state); else passed++;
        total++; if (rd_line_cnt_o !== 13'd3) $display("FAIL frame_cnt got=%0d exp=3", rd_line_cnt_o); else passed++;
    endtask

    task automatic test_pointers();
        do_reset();
        send(1'b1, 1'b0, 1'b0);
        repeat (4) send(1'b0, 1'b1, 1'b0);
        rd_line_done_i = 1'b1;
        tick();
        total++; if (wr_buf_sel_o !== 4'b0001) $display("FAIL ptr_wr got=%b exp=0001", wr_buf_sel_o); else passed++;
        total++; if (rd_buf_mask_o !== 4'b1110) $display("FAIL ptr_mask got=%b exp=1110", rd_buf_mask_o); else passed++;
        total++; if (rd_oldest_idx_o !== 2'd1) $display("FAIL ptr_idx got=%0d exp=1", rd_oldest_idx_o); else passed++;
        total++; if (dut.r_lines_stored !== 3'd3) $display("FAIL ptr_ls got=%0d exp=3", dut.r_lines_stored); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        send(1'b1, 1'b0, 1'b0);
        repeat (4) send(1'b0, 1'b1, 1'b0);
        total++; if (err_overflow_o !== 1'b0) $display("FAIL ovf_early got=%b exp=0", err_overflow_o); else passed++;
        send(1'b0, 1'b1, 1'b0);
        total++; if (err_overflow_o !== 1'b1) $display("FAIL ovf_set got=%b exp=1", err_overflow_o); else passed++;
        total++; if (dut.r_lines_stored !== 3'd4) $display("FAIL ovf_ls got=%0d exp=4", dut.r_lines_stored); else passed++;
        total++; if (wr_buf_sel_o !== 4'b0010) $display("FAIL ovf_wr got=%b exp=0010", wr_buf_sel_o); else passed++;
    endtask

    task automatic test_trunc();
        do_reset();
        rd_ready_i = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        repeat (2) send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        total++; if (err_trunc_o !== 1'b1) $display("FAIL trunc_err got=%b exp=1", err_trunc_o); else passed++;
        total++; if (dut.r_state !== 2'd1) $display("FAIL trunc_state got=%0d exp=1", dut.r_state); else passed++;
        total++; if (wr_buf_sel_o !== 4'b0001) $display("FAIL trunc_wr got=%b exp=0001", wr_buf_sel_o); else passed++;
        total++; if (dut.r_lines_stored !== 3'd0) $display("FAIL trunc_ls got=%0d exp=0", dut.r_lines_stored); else passed++;
        pops = 0;
        repeat (2) send(1'b0, 1'b1, 1'b0);
        idle(5);
        total++; if (pops !== 0) $display("FAIL trunc_nopop got=%0d exp=0", pops); else passed++;
        send(1'b0, 1'b1, 1'b0);
        idle(3);
        total++; if (pops !== 1) $display("FAIL trunc_pop got=%0d exp=1", pops); else passed++;
    endtask

    task automatic test_simul();
        do_reset();
        send(1'b1, 1'b0, 1'b0);
        repeat (2) send(1'b0, 1'b1, 1'b0);
        rd_line_done_i = 1'b1;
        send(1'b0, 1'b1, 1'b0);
        total++; if (dut.r_lines_stored !== 3'd2) $display("FAIL simul_ls got=%0d exp=2", dut.r_lines_stored); else passed++;
        total++; if (wr_buf_sel_o !== 4'b1000) $display("FAIL simul_wr got=%b exp=1000", wr_buf_sel_o); else passed++;
        total++; if (rd_buf_mask_o !== 4'b1110) $display("FAIL simul_mask got=%b exp=1110", rd_buf_mask_o); else passed++;
        total++; if (rd_oldest_idx_o !== 2'd1) $display("FAIL simul_idx got=%0d exp=1", rd_oldest_idx_o); else passed++;
    endtask

    task automatic test_short();
        do_reset();
        rd_ready_i = 1'b1; auto_rd = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        total++; if (dut.r_state !== 2'd1) $display("FAIL short_prime got=%0d exp=1", dut.r_state); else passed++;
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        total++; if (dut.r_state !== 2'd3) $display("FAIL short_flush got=%0d exp=3", dut.r_state); else passed++;
        tick();
        total++; if (dut.r_state !== 2'd0) $display("FAIL short_idle got=%0d exp=0", dut.r_state); else passed++;
        idle(5);
        total++; if (pops !== 0) $display("FAIL short_pops got=%0d exp=0", pops); else passed++;
    endtask

    task automatic test_midreset();
        do_reset();
        rd_ready_i = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        repeat (3) send(1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        #1;
        total++; if (pop_o !== 1'b0) $display("FAIL midrst_pop got=%b exp=0", pop_o); else passed++;
        total++; if (dut.r_state !== 2'd0) $display("FAIL midrst_state got=%0d exp=0", dut.r_state); else passed++;
        tick();
        rst_i = 1'b0;
        pops = 0;
        idle(10);
        total++; if (pops !== 0) $display("FAIL midrst_nopop got=%0d exp=0", pops); else passed++;
        total++; if (rd_line_cnt_o !== 13'd0) $display("FAIL midrst_cnt got=%0d exp=0", rd_line_cnt_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pointers();
        test_overflow();
        test_trunc();
        test_simul();
        test_short();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
